// File: rtl/jam_pkg.sv
// Shared definitions for the JAM job-assignment solver front end.
// Holds the table geometry (N workers x N jobs), the cost and lower-bound
// widths, the loader state encoding and the flat {worker, job} address type.
// The solver core imports this package as well, so keep it dependency-free.
package jam_pkg;

  localparam int N        = 8;    // workers = jobs
  localparam int COST_W   = 7;    // cost entry width
  localparam int SUM_W    = 10;   // lower-bound width (8 x 127 = 1016)
  localparam int COST_MAX = 127;  // largest representable cost
  localparam int IDX_W    = $clog2(N);
  localparam int ADDR_W   = 2 * IDX_W;
  localparam int ENTRIES  = N * N;

  typedef enum logic {
    LOAD  = 1'b0,
    SERVE = 1'b1
  } state_t;

  // Flat table address {worker, job}
  typedef logic [ADDR_W-1:0] addr_t;

  function automatic logic [COST_W-1:0] cost_min(input logic [COST_W-1:0] a,
                                                 input logic [COST_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/jam_row_min_acc.sv
// Row-minimum lower-bound accumulator.
// Tracks the minimum cost seen in the current row of the incoming stream
// and, on the last word of each row, adds that minimum into lb_acc.
//
// Ports:
//   CLK, RST  clock and synchronous active-high reset
//   clr       synchronous clear of row minimum, column count and sum
//   en        one accepted table word is present on data
//   data      cost entry of the accepted word
//   lb_acc    running sum of completed row minima
module jam_row_min_acc
  import jam_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              clr,
  input  logic              en,
  input  logic [COST_W-1:0] data,
  output logic [SUM_W-1:0]  lb_acc
);

  logic [COST_W-1:0] row_min_reg;
  logic [COST_W-1:0] row_min_next;
  logic [IDX_W-1:0]  col_reg;
  logic [SUM_W-1:0]  lb_acc_reg;

  // Minimum including the word being accepted this cycle, so the last word
  // of a row is folded in before the row is summed.
  assign row_min_next = cost_min(row_min_reg, data);

  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      row_min_reg <= COST_W'(COST_MAX);
      col_reg     <= '0;
      lb_acc_reg  <= '0;
    end else if (en) begin
      if (col_reg == IDX_W'(N - 1)) begin
        lb_acc_reg  <= lb_acc_reg + SUM_W'(row_min_next);
        row_min_reg <= COST_W'(COST_MAX);
        col_reg     <= '0;
      end else begin
        row_min_reg <= row_min_next;
        col_reg     <= col_reg + 1'b1;
      end
    end
  end

  assign lb_acc = lb_acc_reg;

endmodule

// File: rtl/jam_cost_loader.sv
// JAM cost-table loader.
// Accepts the N x N cost table as a row-major valid/ready stream, checks
// that in_last marks exactly the final word, stores the table and serves it
// to the solver's combinational W/J lookup port. The solver is held in reset
// (jam_rst) until a well-framed table is loaded. Also reports the sum of row
// minima as a lower bound on the total assignment cost.
//
// Ports:
//   CLK, RST     clock and synchronous active-high reset
//   in_valid     stream word valid
//   in_ready     loader accepts a word (LOAD state, not in reset)
//   in_data      cost entry, worker 0 job 0 first
//   in_last      marks the final word of a table
//   reload       single-cycle request to drop the table (honoured in SERVE)
//   W, J         worker / job lookup index from the solver
//   Cost         cost[W][J], zero while no table is served
//   jam_rst      reset to the solver, high until a table is loaded
//   table_ready  table loaded and being served
//   frame_err    sticky framing error
//   lower_bound  sum over rows of minimum cost
module jam_cost_loader
  import jam_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COST_W-1:0] in_data,
  input  logic              in_last,
  input  logic              reload,
  input  logic [IDX_W-1:0]  W,
  input  logic [IDX_W-1:0]  J,
  output logic [COST_W-1:0] Cost,
  output logic              jam_rst,
  output logic              table_ready,
  output logic              frame_err,
  output logic [SUM_W-1:0]  lower_bound
);

  localparam addr_t ADDR_LAST = addr_t'(ENTRIES - 1);

  state_t            state_reg;
  addr_t             addr_reg;
  logic              table_ready_reg;
  logic              jam_rst_reg;
  logic              frame_err_reg;
  logic [COST_W-1:0] table_mem [ENTRIES];

  logic accept;
  logic at_end;
  logic last_ok;
  logic frame_bad;
  logic wr_en;
  logic acc_en;
  logic acc_clr;

  // in_ready drops combinationally with RST so no word is taken in reset.
  assign in_ready  = (state_reg == LOAD) && !RST;
  assign accept    = in_valid && in_ready;
  assign at_end    = (addr_reg == ADDR_LAST);
  assign last_ok   = accept && at_end && in_last;
  // Early last (last before the end) or missing last (end without last).
  assign frame_bad = accept && (at_end != in_last);
  // A word arriving at the end position without in_last is discarded.
  assign wr_en     = accept && !(at_end && !in_last);
  assign acc_en    = accept && !frame_bad;
  assign acc_clr   = frame_bad || ((state_reg == SERVE) && reload);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg       <= LOAD;
      addr_reg        <= '0;
      table_ready_reg <= 1'b0;
      jam_rst_reg     <= 1'b1;
      frame_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        LOAD: begin
          if (accept) begin
            if (last_ok) begin
              state_reg       <= SERVE;
              table_ready_reg <= 1'b1;
              jam_rst_reg     <= 1'b0;
              addr_reg        <= '0;
            end else if (frame_bad) begin
              frame_err_reg   <= 1'b1;
              addr_reg        <= '0;
            end else begin
              addr_reg        <= addr_reg + 1'b1;
            end
          end
        end
        SERVE: begin
          if (reload) begin
            state_reg       <= LOAD;
            table_ready_reg <= 1'b0;
            jam_rst_reg     <= 1'b1;
            frame_err_reg   <= 1'b0;
            addr_reg        <= '0;
          end
        end
        default: state_reg <= LOAD;
      endcase
    end
  end

  // Table storage: contents are deliberately not reset.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      table_mem[addr_reg] <= in_data;
    end
  end

  // Same-cycle lookup: the solver samples Cost on the falling edge.
  assign Cost = table_ready_reg ? table_mem[{W, J}] : '0;

  jam_row_min_acc u_row_min_acc (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (acc_clr),
    .en     (acc_en),
    .data   (in_data),
    .lb_acc (lower_bound)
  );

  assign jam_rst     = jam_rst_reg;
  assign table_ready = table_ready_reg;
  assign frame_err   = frame_err_reg;

endmodule
